// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
// Provides the data/address widths and the writeback grant encoding.
package regfile_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_P,
    WB_M
  } wb_src_e;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle between the two result producers and the arbiter.
//   p_valid/p_rd/p_data/p_ready : in-order pipeline writeback
//   m_valid/m_rd/m_data/m_ready : long-latency (mul/div) writeback
// master = producer side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic              p_valid;
  logic [REG_AW-1:0] p_rd;
  logic [XLEN-1:0]   p_data;
  logic              p_ready;

  logic              m_valid;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0]   m_data;
  logic              m_ready;

  modport master (
    output p_valid, p_rd, p_data,
    output m_valid, m_rd, m_data,
    input  p_ready, m_ready
  );

  modport slave (
    input  p_valid, p_rd, p_data,
    input  m_valid, m_rd, m_data,
    output p_ready, m_ready
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations.
//   clk, rst          : clock, synchronous active-high reset
//   set_en, set_idx   : mark a register busy (issue of an M operation)
//   clr_en, clr_idx   : mark a register free (M result written back)
//   chk_rs1/rs2/rd    : decode operands to look up
//   hazard            : any looked-up operand is busy (pre-update state)
//   busy              : the busy bits; bit 0 is never set
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_idx,
  input  logic [REG_AW-1:0]   chk_rs1,
  input  logic [REG_AW-1:0]   chk_rs2,
  input  logic [REG_AW-1:0]   chk_rd,
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_next;

  // Clear applied before set so a same-cycle re-issue keeps the bit busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  always_comb begin
    hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline (P)
// and the long-latency unit (M), and tracks M destinations in a scoreboard.
//   clk, rst              : clock, synchronous active-high reset
//   wb (slave)            : P and M valid/ready writeback handshakes
//   iss_valid, iss_rd     : M operation issued this cycle and its destination
//   chk_rs1/rs2/rd        : decode operands checked for hazards
//   hazard, busy          : scoreboard lookup result and busy bits
//   writeEn/Addr/Data     : registered register-file write port
// STARVE_LIMIT: cycles M may be held off before it takes priority (1..15).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 iss_valid,
  input  logic [REG_AW-1:0]    iss_rd,
  input  logic [REG_AW-1:0]    chk_rs1,
  input  logic [REG_AW-1:0]    chk_rs2,
  input  logic [REG_AW-1:0]    chk_rd,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 writeEn,
  output logic [REG_AW-1:0]    writeAddr,
  output logic [XLEN-1:0]      writeData
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starve_at_limit;
  wb_src_e    grant;
  logic       m_xfer;

  assign starve_at_limit = (starve_cnt == LIMIT);

  always_comb begin
    grant      = WB_NONE;
    wb.p_ready = 1'b0;
    wb.m_ready = 1'b0;
    if (!rst) begin
      if (wb.m_valid && (!wb.p_valid || starve_at_limit)) grant = WB_M;
      else if (wb.p_valid)                                grant = WB_P;
    end
    wb.p_ready = (grant == WB_P);
    wb.m_ready = (grant == WB_M);
  end

  assign m_xfer = (grant == WB_M);

  // Counts consecutive cycles M is waiting; saturates so M keeps priority.
  always_ff @(posedge clk) begin
    if (rst)                         starve_cnt <= '0;
    else if (!wb.m_valid || m_xfer)  starve_cnt <= '0;
    else if (!starve_at_limit)       starve_cnt <= starve_cnt + 4'd1;
  end

  // x0 grants are accepted but never enabled; address/data still load.
  always_ff @(posedge clk) begin
    if (rst) begin
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else begin
      unique case (grant)
        WB_P: begin
          writeEn   <= (wb.p_rd != '0);
          writeAddr <= wb.p_rd;
          writeData <= wb.p_data;
        end
        WB_M: begin
          writeEn   <= (wb.m_rd != '0);
          writeAddr <= wb.m_rd;
          writeData <= wb.m_data;
        end
        default: writeEn <= 1'b0;
      endcase
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (iss_valid),
    .set_idx (iss_rd),
    .clr_en  (m_xfer),
    .clr_idx (wb.m_rd),
    .chk_rs1 (chk_rs1),
    .chk_rs2 (chk_rs2),
    .chk_rd  (chk_rd),
    .hazard  (hazard),
    .busy    (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_regfile_wb_arbiter;
  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic        hazard;
  logic [31:0] busy;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .chk_rd    (chk_rd),
    .hazard    (hazard),
    .busy      (busy),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [31:0]   m_busy;
  int unsigned m_wait;
  bit          exp_p_ready, exp_m_ready, exp_hazard;
  bit          exp_we;
  bit [4:0]    exp_wa;
  bit [31:0]   exp_wd;
  // Combinational outputs captured at the negedge before each posedge
  logic        obs_p_ready, obs_m_ready, obs_hazard;

  // Drives one cycle of inputs, samples combinational outputs mid-cycle,
  // and advances the model across the posedge. No checking here.
  task automatic drive_cycle(input bit r,
                             input bit pv, input bit [4:0] prd, input bit [31:0] pd,
                             input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                             input bit iv, input bit [4:0] ird,
                             input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
    bit p_take, m_take;
    rst = r;
    wb.p_valid = pv; wb.p_rd = prd; wb.p_data = pd;
    wb.m_valid = mv; wb.m_rd = mrd; wb.m_data = md;
    iss_valid = iv; iss_rd = ird;
    chk_rs1 = rs1; chk_rs2 = rs2; chk_rd = rd;
    @(negedge clk);
    obs_p_ready = wb.p_ready;
    obs_m_ready = wb.m_ready;
    obs_hazard  = hazard;
    // M wins when alone or after being held off LIMIT cycles in a row.
    m_take = !r && mv && (!pv || m_wait == LIMIT);
    p_take = !r && pv && !m_take;
    exp_p_ready = p_take;
    exp_m_ready = m_take;
    exp_hazard  = m_busy[rs1] | m_busy[rs2] | m_busy[rd];
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = '0; m_wait = 0; exp_we = 0; exp_wa = '0; exp_wd = '0;
    end else begin
      if (p_take)      begin exp_we = (prd != 0); exp_wa = prd; exp_wd = pd; end
      else if (m_take) begin exp_we = (mrd != 0); exp_wa = mrd; exp_wd = md; end
      else             exp_we = 0;
      if (m_take || !mv) m_wait = 0;
      else if (m_wait < LIMIT) m_wait = m_wait + 1;
      if (m_take) m_busy[mrd] = 1'b0;
      if (iv && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 1, 3, 32'h1, 1, 4, 32'h2, 1, 5, 0, 0, 0);
    total++;
    if (obs_p_ready !== 1'b0 || obs_m_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got p=%b m=%b want 0 0", obs_p_ready, obs_m_ready);
    end
    total++;
    if (writeEn !== 1'b0 || writeAddr !== 5'd0 || writeData !== 32'd0) begin
      bad++; $display("FAIL reset_write: got en=%b addr=%0d data=%h want 0 0 0", writeEn, writeAddr, writeData);
    end
    total++;
    if (busy !== 32'd0 || hazard !== 1'b0) begin
      bad++; $display("FAIL reset_busy: got busy=%h hazard=%b want 0 0", busy, hazard);
    end
    total++;
    if (dut.starve_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt);
    end
  endtask

  task automatic test_p_stream();
    bit [4:0]  rds [3] = '{5'd5, 5'd6, 5'd7};
    bit [31:0] dts [3] = '{32'hA, 32'hB, 32'hC};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, rds[i], dts[i], 0, 0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs_p_ready !== 1'b1) begin
        bad++; $display("FAIL p_stream_ready[%0d]: got %b want 1", i, obs_p_ready);
      end
      total++;
      if (writeEn !== 1'b1 || writeAddr !== rds[i] || writeData !== dts[i]) begin
        bad++; $display("FAIL p_stream_write[%0d]: got en=%b addr=%0d data=%h want 1 %0d %h",
                        i, writeEn, writeAddr, writeData, rds[i], dts[i]);
      end
    end
  endtask

  task automatic test_idle_hold();
    idle();
    total++;
    if (writeEn !== 1'b0 || writeAddr !== 5'd7 || writeData !== 32'hC) begin
      bad++; $display("FAIL idle_hold: got en=%b addr=%0d data=%h want 0 7 c", writeEn, writeAddr, writeData);
    end
  endtask

  task automatic test_starve();
    for (int i = 0; i < 15; i++) begin
      bit want_m;
      want_m = ((i % 5) == 4);
      drive_cycle(0, 1, 5'd1, 32'h100 + i, 1, 5'd2, 32'h200 + i, 0, 0, 0, 0, 0);
      total++;
      if (obs_m_ready !== want_m || obs_p_ready !== !want_m) begin
        bad++; $display("FAIL starve_grant[%0d]: got p=%b m=%b want p=%b m=%b",
                        i, obs_p_ready, obs_m_ready, !want_m, want_m);
      end
      total++;
      if (writeAddr !== (want_m ? 5'd2 : 5'd1) || writeData !== (want_m ? 32'h200 + i : 32'h100 + i)) begin
        bad++; $display("FAIL starve_write[%0d]: got addr=%0d data=%h", i, writeAddr, writeData);
      end
      total++;
      if (dut.starve_cnt !== 4'((i % 5) == 4 ? 0 : (i % 5) + 1)) begin
        bad++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", i, dut.starve_cnt, (i % 5) == 4 ? 0 : (i % 5) + 1);
      end
    end
    idle();
  endtask

  task automatic test_hazard();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 0);
    total++;
    if (obs_hazard !== 1'b0) begin
      bad++; $display("FAIL hazard_issue_cycle: got %b want 0", obs_hazard);
    end
    drive_cycle(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 0, 0);
    total++;
    if (obs_hazard !== 1'b1 || obs_m_ready !== 1'b1) begin
      bad++; $display("FAIL hazard_set: got hazard=%b m_ready=%b want 1 1", obs_hazard, obs_m_ready);
    end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0);
    total++;
    if (obs_hazard !== 1'b0 || busy[9] !== 1'b0) begin
      bad++; $display("FAIL hazard_clear: got hazard=%b busy9=%b want 0 0", obs_hazard, busy[9]);
    end
  endtask

  task automatic test_same_cycle();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 1, 5'd12, 32'h12, 1, 5'd12, 0, 0, 0);
    total++;
    if (busy[12] !== 1'b1 || writeAddr !== 5'd12 || writeEn !== 1'b1) begin
      bad++; $display("FAIL same_cycle: got busy12=%b en=%b addr=%0d want 1 1 12", busy[12], writeEn, writeAddr);
    end
    drive_cycle(0, 0, 0, 0, 1, 5'd12, 32'h12, 0, 0, 0, 0, 0);
    idle();
  endtask

  task automatic test_x0();
    drive_cycle(0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 1, 5'd0, 0, 0, 0);
    total++;
    if (obs_p_ready !== 1'b1 || writeEn !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL x0_write: got ready=%b en=%b busy0=%b want 1 0 0", obs_p_ready, writeEn, busy[0]);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
    drive_cycle(0, 1, 5'd3, 32'h33, 1, 5'd8, 32'h88, 0, 0, 0, 0, 0);
    total++;
    if (busy !== 32'h0000_0300 || obs_m_ready !== 1'b0) begin
      bad++; $display("FAIL mid_setup: got busy=%h m_ready=%b want 00000300 0", busy, obs_m_ready);
    end
    drive_cycle(1, 1, 5'd3, 32'h33, 1, 5'd8, 32'h88, 0, 0, 0, 0, 0);
    total++;
    if (obs_p_ready !== 1'b0 || obs_m_ready !== 1'b0) begin
      bad++; $display("FAIL mid_ready: got p=%b m=%b want 0 0", obs_p_ready, obs_m_ready);
    end
    total++;
    if (busy !== 32'd0 || writeEn !== 1'b0 || dut.starve_cnt !== 4'd0) begin
      bad++; $display("FAIL mid_state: got busy=%h en=%b starve=%0d want 0 0 0", busy, writeEn, dut.starve_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 49) == 0),
                  bit'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  bit'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  bit'($urandom_range(0, 1)), 5'($urandom),
                  5'($urandom), 5'($urandom), 5'($urandom));
      total++;
      if (obs_p_ready !== exp_p_ready || obs_m_ready !== exp_m_ready || obs_hazard !== exp_hazard) begin
        bad++; $display("FAIL rand_comb[%0d]: got p=%b m=%b hz=%b want p=%b m=%b hz=%b",
                        i, obs_p_ready, obs_m_ready, obs_hazard, exp_p_ready, exp_m_ready, exp_hazard);
      end
      total++;
      if (writeEn !== exp_we || (exp_we && (writeAddr !== exp_wa || writeData !== exp_wd))) begin
        bad++; $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                        i, writeEn, writeAddr, writeData, exp_we, exp_wa, exp_wd);
      end
      total++;
      if (busy !== m_busy || dut.starve_cnt !== 4'(m_wait)) begin
        bad++; $display("FAIL rand_state[%0d]: got busy=%h starve=%0d want busy=%h starve=%0d",
                        i, busy, dut.starve_cnt, m_busy, m_wait);
      end
    end
  endtask

  initial begin
    m_busy = '0; m_wait = 0; exp_we = 0; exp_wa = '0; exp_wd = '0;
    rst = 1'b1;
    wb.p_valid = 0; wb.p_rd = 0; wb.p_data = 0;
    wb.m_valid = 0; wb.m_rd = 0; wb.m_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    test_reset();
    test_p_stream();
    test_idle_hold();
    test_starve();
    test_hazard();
    test_same_cycle();
    test_x0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
